// File: rtl/led_mux_pkg.sv
// Shared types and constants for the LED scan multiplexer: state encoding,
// a constant clog2 and the all-off segment pattern for common-anode displays.
package led_mux_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Segments are active-low on common-anode parts, so all ones means dark.
  localparam logic [63:0] BLANK_SEG_ALL = '1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/led_scan_prescaler.sv
// Scan-rate prescaler: counts 0..PRESCALE-1 and pulses tick on the last count.
// tick is decoded from the counter register; no backpressure, free-running.
module led_scan_prescaler
  import led_mux_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_scan_mux.sv
// Multi-digit LED scanner with blanking, per-digit enable and optional PWM dimming
// (LED_SCAN_MUX_BRIGHTNESS_EN); outputs are registered, updated on the slot edge, no backpressure.
module led_scan_mux
  import led_mux_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SEG_W       = 8,
  parameter int PRESCALE    = 50000,
  parameter int DWELL_TICKS = 4,
  parameter int BLANK_TICKS = 1,
  parameter logic [SEG_W-1:0] BLANK_SEG = BLANK_SEG_ALL[SEG_W-1:0]
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       dig_en,
`ifdef LED_SCAN_MUX_BRIGHTNESS_EN
  input  logic [3:0]                  brightness,
`endif
  output logic [NUM_DIGITS-1:0]       sel_n,
  output logic [SEG_W-1:0]            seg_out,
  output logic                        frame_start
);

  localparam int IW    = clog2(NUM_DIGITS);
  localparam int MAX_T = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int PW    = clog2(MAX_T + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] DW_LAST  = PW'(DWELL_TICKS - 1);
  localparam logic [PW-1:0] BT_LAST  = PW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

  logic tick;

  led_scan_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  scan_state_t           state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [IW-1:0]         idx_q, idx_d, nxt_idx;
  logic                  first_q, first_d;
  logic [NUM_DIGITS-1:0] sel_hold_q, sel_hold_d;
  logic [NUM_DIGITS-1:0] sel_n_q, sel_n_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  frame_q, frame_d;
  logic                  show_entry, blank_entry;

  // All transitions happen on a tick, so with no blanking the first slot
  // is still a full DWELL_TICKS*PRESCALE long.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    first_d     = first_q;
    sel_hold_d  = sel_hold_q;
    seg_d       = seg_q;
    frame_d     = 1'b0;
    show_entry  = 1'b0;
    blank_entry = 1'b0;
    nxt_idx     = (first_q || idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    if (tick) begin
      phase_d = phase_q + PW'(1);
      case (state_q)
        BLANK: if (phase_q == BT_LAST) show_entry = 1'b1;
        SHOW: begin
          if (phase_q == DW_LAST) begin
            if (BLANK_TICKS > 0) blank_entry = 1'b1;
            else                 show_entry  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (show_entry) begin
      state_d = SHOW;
      phase_d = '0;
      idx_d   = nxt_idx;
      first_d = 1'b0;
      frame_d = (nxt_idx == '0);
      // Disabled digits still consume their slot to keep the refresh rate fixed.
      if (dig_en[nxt_idx]) begin
        sel_hold_d = ~(NUM_DIGITS'(1) << nxt_idx);
        seg_d      = seg_in[nxt_idx*SEG_W +: SEG_W];
      end else begin
        sel_hold_d = '1;
        seg_d      = BLANK_SEG;
      end
    end

    if (blank_entry) begin
      state_d    = BLANK;
      phase_d    = '0;
      sel_hold_d = '1;
      seg_d      = BLANK_SEG;
    end
  end

`ifdef LED_SCAN_MUX_BRIGHTNESS_EN
  logic [3:0] pwm_q, pwm_d;

  // Gate against the next PWM value so the pad register stays in step with it.
  always_comb begin
    pwm_d   = (pwm_q == 4'd14) ? 4'd0 : pwm_q + 4'd1;
    sel_n_d = (pwm_d < brightness) ? sel_hold_d : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 4'd0;
    else        pwm_q <= pwm_d;
  end
`else
  always_comb begin
    sel_n_d = sel_hold_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BLANK;
      phase_q    <= '0;
      idx_q      <= '0;
      first_q    <= 1'b1;
      sel_hold_q <= '1;
      sel_n_q    <= '1;
      seg_q      <= BLANK_SEG;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      first_q    <= first_d;
      sel_hold_q <= sel_hold_d;
      sel_n_q    <= sel_n_d;
      seg_q      <= seg_d;
      frame_q    <= frame_d;
    end
  end

  assign sel_n       = sel_n_q;
  assign seg_out     = seg_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_led_scan_mux.sv
// Directed bench: a 4-digit scanner with blanking and one without, checked
// every cycle against hand-derived slot timing, plus mid-slot edits and reset.
module tb_led_scan_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] seg_in;
  logic [3:0]  dig_en;
  logic [31:0] seg_in1;
  logic [3:0]  dig_en1;
  logic [3:0]  sel_n0, sel_n1;
  logic [7:0]  seg_out0, seg_out1;
  logic        frame0, frame1;
`ifdef LED_SCAN_MUX_BRIGHTNESS_EN
  logic [3:0]  brightness = 4'hF;
`endif

  led_scan_mux #(
    .NUM_DIGITS(4), .SEG_W(8), .PRESCALE(2), .DWELL_TICKS(3), .BLANK_TICKS(1)
  ) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dig_en     (dig_en),
`ifdef LED_SCAN_MUX_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .sel_n      (sel_n0),
    .seg_out    (seg_out0),
    .frame_start(frame0)
  );

  led_scan_mux #(
    .NUM_DIGITS(4), .SEG_W(8), .PRESCALE(2), .DWELL_TICKS(3), .BLANK_TICKS(0)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in1),
    .dig_en     (dig_en1),
`ifdef LED_SCAN_MUX_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .sel_n      (sel_n1),
    .seg_out    (seg_out1),
    .frame_start(frame1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int t;
  logic [3:0] m0_sel;
  logic [7:0] m0_seg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_sel0", {28'd0, sel_n0}, 32'hF);
    chk("rst_seg0", {24'd0, seg_out0}, 32'hFF);
    chk("rst_frm0", {31'd0, frame0}, 32'h0);
    chk("rst_sel1", {28'd0, sel_n1}, 32'hF);
    chk("rst_seg1", {24'd0, seg_out1}, 32'hFF);
    chk("rst_frm1", {31'd0, frame1}, 32'h0);
  endtask

  // t counts clk edges since reset release. dut0: first SHOW at t=2, 8-clk slots
  // shown for 6. dut1: first SHOW at t=2, 6-clk slots shown throughout.
  task automatic check_now();
    int k, r, d;
    logic [3:0] es;
    logic [7:0] eg;
    logic       ef;
    es = 4'hF; eg = 8'hFF; ef = 1'b0;
    if (t >= 2) begin
      k = (t - 2) / 8; r = (t - 2) % 8; d = k % 4;
      if (r == 0) begin
        if (dig_en[d]) begin
          m0_sel = ~(4'b0001 << d);
          m0_seg = seg_in[d*8 +: 8];
        end else begin
          m0_sel = 4'hF;
          m0_seg = 8'hFF;
        end
      end
      if (r < 6) begin es = m0_sel; eg = m0_seg; end
      ef = (r == 0) && (d == 0);
    end
    chk("sel0", {28'd0, sel_n0}, {28'd0, es});
    chk("seg0", {24'd0, seg_out0}, {24'd0, eg});
    chk("frm0", {31'd0, frame0}, {31'd0, ef});
    chk("onehot0", {31'd0, ($countones(~sel_n0) <= 1)}, 32'd1);

    es = 4'hF; eg = 8'hFF; ef = 1'b0;
    if (t >= 2) begin
      k = (t - 2) / 6; d = k % 4;
      es = ~(4'b0001 << d);
      eg = seg_in1[d*8 +: 8];
      ef = ((t - 2) % 6 == 0) && (d == 0);
    end
    chk("sel1", {28'd0, sel_n1}, {28'd0, es});
    chk("seg1", {24'd0, seg_out1}, {24'd0, eg});
    chk("frm1", {31'd0, frame1}, {31'd0, ef});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
    check_now();
  endtask

  initial begin
    rst_n   = 1'b0;
    seg_in  = 32'h44_33_22_11;
    dig_en  = 4'hF;
    seg_in1 = 32'h44_33_22_11;
    dig_en1 = 4'hF;
    m0_sel  = 4'hF;
    m0_seg  = 8'hFF;
    t       = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();

    rst_n = 1'b1;
    t = 0;
    check_now();
    for (int i = 0; i < 84; i++) begin
      step();
      // digit 1 shows t=10..15; edit its data mid-slot, visible next frame at t=42
      if (t == 12) seg_in[15:8] = 8'hAA;
      // frame 1: digit 2 slot (t=50..55) runs dark, frame 2 back to normal
      if (t == 36) dig_en = 4'b1011;
      if (t == 70) dig_en = 4'hF;
    end

    // t=84 is mid-SHOW of digit 2 in frame 2
    chk("pre_rst_sel0", {28'd0, sel_n0}, 32'h0000000B);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = 0;
    check_now();
    for (int i = 0; i < 14; i++) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
